// File: rtl/light_phase_sequencer.sv
// Intersection lamp sequencer: enforces min/max green, yellow and all-red times; one-cycle handshake, lamps registered-decode.
// Backpressure: req_ready only late in green (timer >= MIN_GREEN-1); requests held while not ready are left unconsumed.
module light_phase_sequencer #(
  parameter int MIN_GREEN = 20,
  parameter int MAX_GREEN = 60,
  parameter int YELLOW    = 4,
  parameter int ALLRED    = 2,
  parameter int CW        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_dir,
  input  logic       req_valid,
  output logic       req_ready,
  output logic [3:0] green,
  output logic [3:0] yellow,
  output logic [3:0] red,
  output logic       green_start,
  output logic       err_onehot
);

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2
  } state_e;

  localparam logic [CW-1:0] MIN_GREEN_LAST = CW'(MIN_GREEN - 1);
  localparam logic [CW-1:0] MAX_GREEN_LAST = CW'(MAX_GREEN - 1);
  localparam logic [CW-1:0] YELLOW_LAST    = CW'(YELLOW - 1);
  localparam logic [CW-1:0] ALLRED_LAST    = CW'(ALLRED - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] timer_q, timer_d;
  logic [3:0]    cur_dir_q, cur_dir_d;
  logic [3:0]    next_dir_q, next_dir_d;
  logic          err_q, err_d;

  logic          req_onehot;
  logic          accept;

  assign req_onehot = (req_dir != 4'b0000) && ((req_dir & (req_dir - 4'd1)) == 4'b0000);
  assign accept     = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q + 1'b1;
    cur_dir_d   = cur_dir_q;
    next_dir_d  = next_dir_q;
    err_d       = 1'b0;
    req_ready   = 1'b0;
    green_start = 1'b0;
    green       = 4'b0000;
    yellow      = 4'b0000;
    red         = 4'b1111;

    case (state_q)
      ST_ALL_RED: begin
        if (timer_q == ALLRED_LAST) begin
          state_d   = ST_GREEN;
          timer_d   = '0;
          cur_dir_d = next_dir_q;
        end
      end
      ST_GREEN: begin
        green       = cur_dir_q;
        red         = ~cur_dir_q;
        req_ready   = (timer_q >= MIN_GREEN_LAST);
        green_start = (timer_q == '0);
        err_d       = accept && !req_onehot;
        // An explicit different-direction request takes priority over the max-green rotation.
        if (accept && req_onehot && (req_dir != cur_dir_q)) begin
          state_d    = ST_YELLOW;
          timer_d    = '0;
          next_dir_d = req_dir;
        end else if (timer_q == MAX_GREEN_LAST) begin
          state_d    = ST_YELLOW;
          timer_d    = '0;
          next_dir_d = {cur_dir_q[2:0], cur_dir_q[3]};
        end
      end
      ST_YELLOW: begin
        yellow = cur_dir_q;
        red    = ~cur_dir_q;
        if (timer_q == YELLOW_LAST) begin
          state_d = ST_ALL_RED;
          timer_d = '0;
        end
      end
      default: begin
        state_d = ST_ALL_RED;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ALL_RED;
      timer_q    <= '0;
      cur_dir_q  <= 4'b0000;
      next_dir_q <= 4'b0001;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      cur_dir_q  <= cur_dir_d;
      next_dir_q <= next_dir_d;
      err_q      <= err_d;
    end
  end

  assign err_onehot = err_q;

endmodule

// File: doc/light_phase_sequencer.md
# light_phase_sequencer

Consumes the one-hot direction choice from the largest-lane selector (0001=N, 0010=E, 0100=S, 1000=W). Drives the per-direction green, yellow and red lamp outputs of the intersection. Enforces minimum green, maximum green, yellow and all-red clearance times, with a valid/ready handshake toward the selector. This block is the consumer end of the selector's direction output; it sits between lane arbitration and the lamp drivers.

## Interface
- MIN_GREEN, default 20: minimum green cycles before a change request is accepted; 1 ≤ MIN_GREEN ≤ MAX_GREEN.
- MAX_GREEN, default 60: hard upper bound on green cycles; MAX_GREEN < 2^CW.
- YELLOW, default 4: yellow cycles; ≥ 1.
- ALLRED, default 2: all-red clearance cycles; ≥ 1.
- CW, default 8: phase timer width.
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_dir  in  4  one-hot requested direction from the selector.
- req_valid  in  1  req_dir is valid.
- req_ready  out  1  sequencer accepts a request this cycle.
- green  out  4  per-direction green lamp, bit order N,E,S,W = [0..3].
- yellow  out  4  per-direction yellow lamp.
- red  out  4  per-direction red lamp.
- green_start  out  1  one-cycle pulse in the first cycle of every green phase.
- err_onehot  out  1  one-cycle pulse when an accepted req_dir is not one-hot.

## Operation
- States: ALL_RED, GREEN, YELLOW. Registers: state, timer[CW-1:0], cur_dir[3:0], next_dir[3:0].
- Each state resets timer to 0 on entry. Timer increments every cycle in the state.
- A state of length N exits on the edge where timer == N-1.
- ALL_RED:
  - red = 1111, green = yellow = 0000.
  - After ALLRED cycles, go to GREEN with cur_dir <= next_dir.
- GREEN:
  - green = cur_dir, red = ~cur_dir, yellow = 0000.
  - req_ready = 1 when timer ≥ MIN_GREEN-1; req_ready is 0 in all other states.
  - Handshake completes on an edge where req_valid && req_ready.
  - Accepted req_dir is one-hot and ≠ cur_dir: next_dir <= req_dir, go to YELLOW.
  - Accepted req_dir == cur_dir: request is consumed and ignored; green continues.
  - Accepted req_dir is not one-hot (zero or multi-bit): request is dropped, err_onehot pulses the following cycle, green continues.
  - timer == MAX_GREEN-1 with no valid different-direction acceptance on that edge: next_dir <= clockwise rotation of cur_dir (N→E→S→W→N), go to YELLOW.
  - Same edge carries a valid different-direction acceptance and MAX_GREEN-1: the requested direction wins over rotation.
- YELLOW:
  - yellow = cur_dir, red = ~cur_dir, green = 0000.
  - After YELLOW cycles, go to ALL_RED.
- Exactly one of green/yellow/red is set per direction in every cycle.
- green_start = (state == GREEN && timer == 0).
- Lamp outputs are decoded only from registered state. req_ready and green_start are combinational from registers; they never depend on req_valid or req_dir.

## Timing
- Reset, asserted asynchronously at any time including mid-phase, immediately sets:
  - state = ALL_RED, timer = 0, cur_dir = 0000, next_dir = 0001.
  - red = 1111, green = yellow = 0000.
  - req_ready = 0, green_start = 0, err_onehot = 0.
- After reset release, the first green is N, entered ALLRED cycles later.
- Request latency: acceptance at edge k puts yellow on the old direction from cycle k+1. The new green appears after YELLOW + ALLRED cycles, with green_start in that first cycle.
- Green length is between MIN_GREEN and MAX_GREEN cycles inclusive.
- A request held valid while req_ready = 0 is not consumed. The selector holds or updates req_dir freely until acceptance.

## Test plan
- Free-run, MIN_GREEN=3, MAX_GREEN=5, YELLOW=2, ALLRED=1, req_valid=0 -> red=1111 for 1 cycle; green=0001 for 5 cycles (green_start in first); yellow=0001 for 2; all-red 1; then green=0010.
- Same params, req_valid=1, req_dir=0100 from reset -> req_ready rises in third N-green cycle; accepted there; yellow=0001 next cycle; green=0100 three cycles later.
- req_dir=0001 held valid while N green -> accepted and ignored; N stays green until MAX_GREEN, then rotates to E.
- req_dir=0011 valid at req_ready -> err_onehot pulses one cycle; green=0001 unchanged; later rotation to E proceeds normally.
- req_dir=1000 first presented exactly at timer=MAX_GREEN-1 of N green -> next green is W (1000), not E.
- Assert rst_n=0 mid-YELLOW between clock edges -> red=1111, green=yellow=0000, req_ready=0 without waiting for a clock; after release, first green is N.
